regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (waddr_rd/wdata_rd/we) between two writeback requesters: the ALU and the load/memory unit.
- Uses round-robin arbitration with a valid/ready handshake and a one-stage registered write output.
- Optionally forwards the in-flight write onto the rs1/rs2 read data paths.
- Sits between the execute/memory writeback stages and register_file.

---
 rtl/regfile_wb_arbiter.sv | 117 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file's single write port (ALU vs. load unit).
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_wb_arbiter #(
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 32,
    parameter bit          ALU_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hold,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          we,
    output logic [AW-1:0] waddr_rd,
    output logic [DW-1:0] wdata_rd,
    input  logic [AW-1:0] raddr_rs1,
    input  logic [AW-1:0] raddr_rs2,
    input  logic [DW-1:0] rf_rdata_rs1,
    input  logic [DW-1:0] rf_rdata_rs2,
    output logic [DW-1:0] rdata_rs1,
    output logic [DW-1:0] rdata_rs2,
    output logic          wb_src
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e          last_grant_q, last_grant_d;
    src_e          wb_src_q,     wb_src_d;
    logic          we_q,         we_d;
    logic [AW-1:0] waddr_q,      waddr_d;
    logic [DW-1:0] wdata_q,      wdata_d;
    logic          alu_gnt,      mem_gnt;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (!hold) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == SRC_MEM) alu_gnt = 1'b1;
                else                         mem_gnt = 1'b1;
            end else begin
                alu_gnt = alu_valid;
                mem_gnt = mem_valid;
            end
        end
    end

    // x0 writes are accepted and advance the pointer but never reach the write port.
    always_comb begin
        last_grant_d = last_grant_q;
        wb_src_d     = wb_src_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        if (alu_gnt) begin
            last_grant_d = SRC_ALU;
            if (alu_rd != '0) begin
                we_d     = 1'b1;
                waddr_d  = alu_rd;
                wdata_d  = alu_data;
                wb_src_d = SRC_ALU;
            end
        end else if (mem_gnt) begin
            last_grant_d = SRC_MEM;
            if (mem_rd != '0) begin
                we_d     = 1'b1;
                waddr_d  = mem_rd;
                wdata_d  = mem_data;
                wb_src_d = SRC_MEM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ALU_FIRST ? SRC_MEM : SRC_ALU;
            wb_src_q     <= SRC_ALU;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wb_src_q     <= wb_src_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;
    assign we        = we_q;
    assign waddr_rd  = waddr_q;
    assign wdata_rd  = wdata_q;
    assign wb_src    = wb_src_q;

`ifdef REGFILE_BYPASS_EN
    assign rdata_rs1 = (we_q && (raddr_rs1 == waddr_q) && (raddr_rs1 != '0)) ? wdata_q : rf_rdata_rs1;
    assign rdata_rs2 = (we_q && (raddr_rs2 == waddr_q) && (raddr_rs2 != '0)) ? wdata_q : rf_rdata_rs2;
`else
    logic unused_raddr;
    assign unused_raddr = ^{raddr_rs1, raddr_rs2};
    assign rdata_rs1    = rf_rdata_rs1;
    assign rdata_rs2    = rf_rdata_rs2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter with a request-queue reference model and a register file.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          hold = 1'b0;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready;
    logic          we;
    logic [AW-1:0] waddr_rd;
    logic [DW-1:0] wdata_rd;
    logic [AW-1:0] raddr_rs1 = '0, raddr_rs2 = '0;
    logic [DW-1:0] rf_rdata_rs1, rf_rdata_rs2;
    logic [DW-1:0] rdata_rs1, rdata_rs2;
    logic          wb_src;

    regfile_wb_arbiter #(.AW(AW), .DW(DW), .ALU_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .we(we), .waddr_rd(waddr_rd), .wdata_rd(wdata_rd),
        .raddr_rs1(raddr_rs1), .raddr_rs2(raddr_rs2),
        .rf_rdata_rs1(rf_rdata_rs1), .rf_rdata_rs2(rf_rdata_rs2),
        .rdata_rs1(rdata_rs1), .rdata_rs2(rdata_rs2), .wb_src(wb_src)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT's write port.
    logic [DW-1:0] rf [32];
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (we) rf[waddr_rd] <= wdata_rd;
    assign rf_rdata_rs1 = rf[raddr_rs1];
    assign rf_rdata_rs2 = rf[raddr_rs2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending requests per source plus expected write-port contents.
    req_t          alu_q[$], mem_q[$];
    logic [AW-1:0] grant_log[$];
    logic [DW-1:0] mdl_rf [32];
    bit            m_last_mem;
    bit            exp_we;
    logic [AW-1:0] exp_waddr;
    logic [DW-1:0] exp_wdata;
    bit            exp_src;
    int            cur_g;  // 0 none, 1 ALU, 2 MEM

    initial for (int i = 0; i < 32; i++) mdl_rf[i] = '0;

    function automatic int exp_grant();
        if (hold) return 0;
        if (alu_valid && !mem_valid) return 1;
        if (mem_valid && !alu_valid) return 2;
        if (alu_valid && mem_valid) return m_last_mem ? 1 : 2;
        return 0;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (BYP && exp_we && a == exp_waddr && a != 0) return exp_wdata;
        return mdl_rf[a];
    endfunction

    task automatic model_reset();
        m_last_mem = 1'b1;
        exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_src = 1'b0;
        alu_q.delete(); mem_q.delete();
    endtask

    task automatic drive_comb();
        alu_valid = (alu_q.size() != 0);
        mem_valid = (mem_q.size() != 0);
        if (alu_valid) begin alu_rd = alu_q[0].rd; alu_data = alu_q[0].data; end
        if (mem_valid) begin mem_rd = mem_q[0].rd; mem_data = mem_q[0].data; end
        #1;
        cur_g = exp_grant();
        chk("alu_ready", alu_ready, cur_g == 1);
        chk("mem_ready", mem_ready, cur_g == 2);
        chk("rdata_rs1", rdata_rs1, exp_rd(raddr_rs1));
        chk("rdata_rs2", rdata_rs2, exp_rd(raddr_rs2));
        if (alu_ready && alu_valid) grant_log.push_back(alu_rd);
        if (mem_ready && mem_valid) grant_log.push_back(mem_rd);
    endtask

    task automatic edge_update();
        req_t r;
        @(posedge clk); #1;
        if (exp_we && exp_waddr != 0) mdl_rf[exp_waddr] = exp_wdata;
        exp_we = 1'b0;
        if (cur_g != 0) begin
            if (cur_g == 1) r = alu_q.pop_front();
            else            r = mem_q.pop_front();
            m_last_mem = (cur_g == 2);
            if (r.rd != 0) begin
                exp_we = 1'b1; exp_waddr = r.rd; exp_wdata = r.data; exp_src = (cur_g == 2);
            end
        end
        chk("we", we, exp_we);
        chk("waddr_rd", waddr_rd, exp_waddr);
        chk("wdata_rd", wdata_rd, exp_wdata);
        if (exp_we) chk("wb_src", wb_src, exp_src);
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_comb();
        edge_update();
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while ((alu_q.size() + mem_q.size()) != 0 && k < max_cycles) begin
            cycle();
            k++;
        end
        chk("drain_left", alu_q.size() + mem_q.size(), 0);
    endtask

    // Asserts reset mid-cycle with a pending ALU request, holds it across one edge.
    task automatic async_reset();
        #2;
        alu_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_we", we, 0);
        chk("rst_waddr", waddr_rd, 0);
        chk("rst_wdata", wdata_rd, 0);
        chk("rst_wb_src", wb_src, 0);
        model_reset();
        @(posedge clk); #1;
        chk("rst_hold_we", we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] exp_seq [8];

    initial begin
        exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 4, 14};
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        async_reset();

        // Contention right after reset: ALU wins the first tie, then alternation.
        grant_log.delete();
        for (int i = 0; i < 4; i++) begin
            alu_q.push_back('{rd: AW'(i + 1), data: DW'($urandom)});
            mem_q.push_back('{rd: AW'(i + 11), data: DW'($urandom)});
        end
        drain(20);
        chk("contention_count", grant_log.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < grant_log.size()) chk("contention_order", grant_log[i], exp_seq[i]);

        // Single ALU write then read-back on rs1.
        alu_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        cycle();
        chk("single_we", we, 1);
        chk("single_wdata", wdata_rd, 32'hDEADBEEF);
        raddr_rs1 = 5'd5;
        cycle();
        cycle();
        chk("single_readback", rdata_rs1, 32'hDEADBEEF);

        // x0 write is accepted but dropped; a following ALU request still gets through.
        mem_q.push_back('{rd: 5'd0, data: 32'h1234});
        raddr_rs1 = 5'd0;
        cycle();
        chk("x0_we", we, 0);
        alu_q.push_back('{rd: 5'd3, data: 32'hCAFE0003});
        cycle();
        chk("x0_after_alu_we", we, 1);
        cycle();
        chk("x0_reads_zero", rdata_rs1, 0);

        // Hold for 3 cycles with a pending ALU request.
        alu_q.push_back('{rd: 5'd9, data: 32'h99999999});
        hold = 1'b1;
        repeat (3) cycle();
        hold = 1'b0;
        cycle();
        chk("hold_release_we", we, 1);

        // Forwarding in the commit cycle.
        alu_q.push_back('{rd: 5'd7, data: 32'h11111111});
        repeat (3) cycle();
        alu_q.push_back('{rd: 5'd7, data: 32'hA5A5A5A5});
        cycle();
        @(negedge clk);
        raddr_rs1 = 5'd7;
        raddr_rs2 = 5'd0;
        drive_comb();
        chk("byp_rs1", rdata_rs1, BYP ? 32'hA5A5A5A5 : 32'h11111111);
        chk("byp_rs2", rdata_rs2, 0);
        edge_update();

        // Randomized traffic with hold, x0 writes, forwarding reads and one mid-run reset.
        for (int i = 0; i < 500; i++) begin
            if (alu_q.size() == 0 && $urandom_range(2) == 0)
                alu_q.push_back('{rd: ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom), data: DW'($urandom)});
            if (mem_q.size() == 0 && $urandom_range(2) == 0)
                mem_q.push_back('{rd: ($urandom_range(7) == 0) ? AW'(0) : AW'($urandom), data: DW'($urandom)});
            hold = ($urandom_range(5) == 0);
            raddr_rs1 = $urandom_range(1) ? exp_waddr : AW'($urandom);
            raddr_rs2 = $urandom_range(1) ? exp_waddr : AW'($urandom);
            cycle();
            if (i == 250) begin
                async_reset();
                hold = 1'b0;
                alu_q.push_back('{rd: 5'd21, data: DW'($urandom)});
                mem_q.push_back('{rd: 5'd22, data: DW'($urandom)});
                @(negedge clk);
                drive_comb();
                chk("tie_after_reset", alu_ready, 1);
                edge_update();
            end
        end
        hold = 1'b0;
        drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
